signed_calc_scan_ctrl: RTL and testbench
========================================

SIGNED_CALC_SCAN_CTRL -- requirements
Module: signed_calc_scan_ctrl

Interface
REQ-001 Parameter W, default 8: operand width in bits, two's complement, range 4..16.
REQ-002 Parameter NDIG, default 8: number of multiplexed 7-segment digits, range 4..8.
REQ-003 Parameter REFRESH, default 6250: clk cycles each digit stays lit.
REQ-004 clk  in  1  system clock; all state on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 a  in  W  signed operand A, sampled only on an accepted start.
REQ-007 b  in  W  signed operand B, sampled only on an accepted start.
REQ-008 op  in  3  operation select: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 REM, 5 NEG(A), 6 ABS(A), 7 reserved (treated as ADD).
REQ-009 start  in  1  level-sampled request; accepted only in IDLE.
REQ-010 busy  out  1  high while an operation is in progress.
REQ-011 done  out  1  one-cycle pulse when the result register updates.
REQ-012 div0  out  1  sticky error: last DIV/REM had B = 0.
REQ-013 ovf  out  1  last result magnitude exceeds the displayable range.
REQ-014 a_to_g  out  7  segment drive, active-low, bit 6 = a.
REQ-015 dp  out  1  decimal point, constant 1 (off).
REQ-016 an  out  NDIG  digit enables, active-low, exactly one low at a time.

Function
REQ-017 FSM states IDLE, CALC, DONE; IDLE --start--> CALC; CALC --count exhausted--> DONE; DONE --> IDLE unconditionally.
REQ-018 On accepting start: latch a, b, op; busy rises the next cycle.
REQ-019 ADD, SUB, NEG, ABS: CALC lasts 1 cycle; done asserts 2 cycles after start.
REQ-020 MUL: sequential shift-add on magnitudes, W CALC cycles, sign applied at the end; done asserts W+1 cycles after start.
REQ-021 DIV/REM: restoring division on magnitudes, W CALC cycles; quotient sign = sign(A) XOR sign(B); remainder takes the sign of A.
REQ-022 Result register R is 2W bits signed; all operations are sign-extended into R, so R itself never overflows.
REQ-023 DIV/REM with B = 0: skip iteration, R = 0, div0 = 1, same latency as REQ-021; any other completed operation clears div0.
REQ-024 start while busy is ignored; no queueing.
REQ-025 done is high during DONE only; R, ovf, and div0 update on entry to DONE and otherwise hold.
REQ-026 ovf = 1 when |R| >= 16^(NDIG-1).
REQ-027 Refresh counter counts 0..REFRESH-1 and wraps; on wrap the scan index increments modulo NDIG (0 follows NDIG-1).
REQ-028 Digits 0..NDIG-2 show hex nibbles of |R|, least significant first; leading zeros blanked; digit 0 is never blanked.
REQ-029 Digit NDIG-1 shows '-' if R < 0, 'E' if div0, otherwise blank.
REQ-030 When ovf = 1, all digits 0..NDIG-2 show '-'.
REQ-031 an and a_to_g update in the same cycle as the scan index (registered; no glitch between digits).

Reset
REQ-032 While rst_n = 0: state IDLE, R = 0, busy = done = div0 = ovf = 0, counters 0, an = all 1, a_to_g = 7'h7F.
REQ-033 Reset asserted mid-CALC aborts the operation with no done pulse; the first start after release is accepted normally.

Structure
REQ-034 Package calc_pkg holds the op encodings, the FSM state type, and the segment codes for hex 0-F, blank, '-', and 'E'.
REQ-035 Sub-module seg7_decoder: 5-bit symbol in (hex, blank, minus, E), 7-bit active-low segments out, purely combinational.
REQ-036 Arithmetic datapath and scan logic stay in the top module; no other sub-modules.

Verification
REQ-037 W=8: a=-5, b=3, op=MUL, start -> done at cycle 9, R = -15; display "-" on digit 7, "F" on digit 0, digits 1..6 blank.
REQ-038 a=-7, b=2, op=DIV -> R = -3; then op=REM -> R = -1; both with done at W+1 cycles.
REQ-039 a=4, b=0, op=DIV -> R = 0, div0 = 1, digit 7 shows 'E'; then ADD -> div0 = 0.
REQ-040 start pulsed at cycles 0 and 3 with op=MUL -> only one done (cycle 9); the second start is ignored.
REQ-041 rst_n low at CALC cycle 4 -> no done, outputs at reset values; a new ADD 3+4 -> R = 7 after 2 cycles.
REQ-042 NDIG=4, W=8: a=-128, b=-128, MUL -> R = 16384 >= 4096, ovf = 1, digits 0..2 show '-'; an scan order 0,1,2,3,0 at REFRESH intervals.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - op codes, FSM states and 7-segment symbol/segment codes
package calc_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_REM = 3'd4,
        OP_NEG = 3'd5,
        OP_ABS = 3'd6,
        OP_RSV = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Display symbols: 0..15 are hex nibbles, the rest are special glyphs
    localparam logic [4:0] SYM_BLANK = 5'd16;
    localparam logic [4:0] SYM_MINUS = 5'd17;
    localparam logic [4:0] SYM_E     = 5'd18;

    // Active-low segments, bit 6 = a ... bit 0 = g; element n is hex digit n
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
        7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
    };
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h7E;
    localparam logic [6:0] SEG_E     = 7'h30;

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - display symbol to active-low 7-segment pattern
module seg7_decoder
    import calc_pkg::*;
(
    input  logic [4:0] sym,
    output logic [6:0] seg
);

    // Hex symbols index the table; unknown special codes fall back to blank
    always_comb begin
        seg = SEG_BLANK;
        if (!sym[4]) begin
            seg = SEG_HEX[sym[3:0]];
        end else if (sym == SYM_MINUS) begin
            seg = SEG_MINUS;
        end else if (sym == SYM_E) begin
            seg = SEG_E;
        end
    end

endmodule

// File: rtl/signed_calc_scan_ctrl.sv
// rtl/signed_calc_scan_ctrl.sv - sequential signed calculator with multiplexed 7-segment readout
module signed_calc_scan_ctrl
    import calc_pkg::*;
#(
    parameter int W       = 8,
    parameter int NDIG    = 8,
    parameter int REFRESH = 6250
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic [2:0]          op,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                div0,
    output logic                ovf,
    output logic [6:0]          a_to_g,
    output logic                dp,
    output logic [NDIG-1:0]     an
);

    localparam int RW  = 2 * W;
    localparam int CW  = $clog2(W);
    localparam int RCW = $clog2(REFRESH + 1);
    localparam int SW  = $clog2(NDIG);
    localparam logic [63:0] OVF_LIM = 64'd1 << (4 * (NDIG - 1));

    state_e               state, state_nxt;
    op_e                  op_q;
    logic signed [W-1:0]  a_q, b_q;
    logic [CW-1:0]        cnt;
    logic [RW-1:0]        prod, mcand, prod_step;
    logic [W-1:0]         mplier, quot, rem, quot_step, rem_step;
    logic [W:0]           rem_sh, rem_diff;
    logic [W-1:0]         a_mag_in, b_mag_in;
    logic                 div_by0, ovf_calc;
    logic signed [RW-1:0] r, r_calc, ae, be;
    logic [RW-1:0]        r_calc_mag, r_mag;

    logic [RCW-1:0]       ref_cnt;
    logic [SW-1:0]        scan_idx, idx_nxt;
    logic [31:0]          nib_val;
    logic [4:0]           sym;
    logic [6:0]           seg_nxt;

    assign a_mag_in = a[W-1] ? W'(-a) : W'(a);
    assign b_mag_in = b[W-1] ? W'(-b) : W'(b);
    assign ae       = RW'(a_q);
    assign be       = RW'(b_q);
    assign div_by0  = ((op_q == OP_DIV) || (op_q == OP_REM)) && (b_q == '0);
    assign dp       = 1'b1;

    // One iteration of shift-add multiply and restoring divide on magnitudes
    always_comb begin
        prod_step = mplier[0] ? (prod + mcand) : prod;
        rem_sh    = {rem, quot[W-1]};
        rem_diff  = rem_sh - {1'b0, mplier};
        rem_step  = rem_diff[W] ? rem_sh[W-1:0] : rem_diff[W-1:0];
        quot_step = {quot[W-2:0], ~rem_diff[W]};
    end

    // Final signed result as it will be captured on entry to DONE
    always_comb begin
        case (op_q)
            OP_SUB:  r_calc = ae - be;
            OP_MUL:  r_calc = (a_q[W-1] ^ b_q[W-1]) ? -$signed(prod_step) : $signed(prod_step);
            OP_DIV:  r_calc = (a_q[W-1] ^ b_q[W-1]) ? -$signed({{W{1'b0}}, quot_step})
                                                     : $signed({{W{1'b0}}, quot_step});
            OP_REM:  r_calc = a_q[W-1] ? -$signed({{W{1'b0}}, rem_step})
                                       : $signed({{W{1'b0}}, rem_step});
            OP_NEG:  r_calc = -ae;
            OP_ABS:  r_calc = a_q[W-1] ? -ae : ae;
            default: r_calc = ae + be;
        endcase
        if (div_by0) begin
            r_calc = '0;
        end
        r_calc_mag = r_calc[RW-1] ? RW'(-r_calc) : RW'(r_calc);
        ovf_calc   = (64'(r_calc_mag) >= OVF_LIM);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CALC;
            S_CALC:  if (cnt == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // Operand capture, iteration registers and result/flag update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_ADD;
            a_q    <= '0;
            b_q    <= '0;
            cnt    <= '0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            quot   <= '0;
            rem    <= '0;
            r      <= '0;
            div0   <= 1'b0;
            ovf    <= 1'b0;
        end else if (state == S_IDLE) begin
            if (start) begin
                op_q   <= op_e'(op);
                a_q    <= a;
                b_q    <= b;
                cnt    <= (op_e'(op) inside {OP_MUL, OP_DIV, OP_REM}) ? CW'(W - 1) : '0;
                prod   <= '0;
                mcand  <= {{W{1'b0}}, a_mag_in};
                mplier <= b_mag_in;
                quot   <= a_mag_in;
                rem    <= '0;
            end
        end else if (state == S_CALC) begin
            if (op_q == OP_MUL) begin
                prod   <= prod_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end else if (!div_by0) begin
                quot   <= quot_step;
                rem    <= rem_step;
            end
            if (cnt == '0) begin
                r    <= r_calc;
                div0 <= div_by0;
                ovf  <= ovf_calc;
            end else begin
                cnt  <= cnt - CW'(1);
            end
        end
    end

    // Symbol for the digit that becomes lit on the next edge
    always_comb begin
        idx_nxt = scan_idx;
        if (ref_cnt == RCW'(REFRESH - 1)) begin
            idx_nxt = (scan_idx == SW'(NDIG - 1)) ? '0 : scan_idx + SW'(1);
        end
        r_mag   = r[RW-1] ? RW'(-r) : RW'(r);
        nib_val = 32'(r_mag) >> {idx_nxt, 2'b00};
        sym     = SYM_BLANK;
        if (idx_nxt == SW'(NDIG - 1)) begin
            if (r[RW-1])   sym = SYM_MINUS;
            else if (div0) sym = SYM_E;
        end else if (ovf) begin
            sym = SYM_MINUS;
        end else if ((idx_nxt == '0) || (nib_val != 32'd0)) begin
            sym = {1'b0, nib_val[3:0]};
        end
    end

    seg7_decoder u_dec (
        .sym (sym),
        .seg (seg_nxt)
    );

    // Refresh timer, scan index and registered digit/segment drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt  <= '0;
            scan_idx <= '0;
            an       <= '1;
            a_to_g   <= 7'h7F;
        end else begin
            ref_cnt  <= (ref_cnt == RCW'(REFRESH - 1)) ? '0 : ref_cnt + RCW'(1);
            scan_idx <= idx_nxt;
            an       <= ~(NDIG'(1) << idx_nxt);
            a_to_g   <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_signed_calc_scan_ctrl.sv
// tb/tb_signed_calc_scan_ctrl.sv - scoreboard bench for signed_calc_scan_ctrl
module tb_signed_calc_scan_ctrl;

    localparam int W       = 8;
    localparam int NDIG    = 4;
    localparam int REFRESH = 3;

    typedef struct {
        longint r;
        bit     d0;
        bit     ov;
        int     due;
    } exp_t;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic signed [W-1:0] a     = '0;
    logic signed [W-1:0] b     = '0;
    logic [2:0]          op    = '0;
    logic                start = 1'b0;
    logic                busy, done, div0, ovf, dp;
    logic [6:0]          a_to_g;
    logic [NDIG-1:0]     an;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    bit   mon_cap = 1'b0;

    logic [6:0] hex7 [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                              7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    signed_calc_scan_ctrl #(.W(W), .NDIG(NDIG), .REFRESH(REFRESH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .op     (op),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .div0   (div0),
        .ovf    (ovf),
        .a_to_g (a_to_g),
        .dp     (dp),
        .an     (an)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic longint model(input int opv, input int av, input int bv, output bit d0);
        d0 = 1'b0;
        case (opv)
            1: return av - bv;
            2: return longint'(av) * bv;
            3: begin if (bv == 0) begin d0 = 1'b1; return 0; end return av / bv; end
            4: begin if (bv == 0) begin d0 = 1'b1; return 0; end return av % bv; end
            5: return -av;
            6: return (av < 0) ? -av : av;
            default: return av + bv;
        endcase
    endfunction

    function automatic bit over(input longint r);
        longint m;
        m = (r < 0) ? -r : r;
        return m >= (longint'(1) << (4 * (NDIG - 1)));
    endfunction

    function automatic logic [6:0] exp_seg(input longint r, input bit d0, input int i);
        longint m, sh;
        m = (r < 0) ? -r : r;
        if (i == NDIG - 1) return (r < 0) ? 7'h7E : (d0 ? 7'h30 : 7'h7F);
        if (over(r)) return 7'h7E;
        sh = m >> (4 * i);
        if (i > 0 && sh == 0) return 7'h7F;
        return hex7[int'(sh % 16)];
    endfunction

    function automatic int digit_of(input logic [NDIG-1:0] v);
        int d, n;
        d = -1;
        n = 0;
        for (int i = 0; i < NDIG; i++) if (!v[i]) begin d = i; n++; end
        return (n == 1) ? d : -1;
    endfunction

    // Monitor: compare every done against the scoreboard, then read back the display
    always begin : monitor
        exp_t       e;
        logic [6:0] seen [NDIG];
        int         d;
        @(posedge clk);
        #1;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d with no operation outstanding", cyc);
            end else begin
                e = exp_q.pop_front();
                mon_cap = 1'b1;
                chk("result_r", longint'(dut.r), e.r);
                chk("div0", longint'(div0), longint'(e.d0));
                chk("ovf", longint'(ovf), longint'(e.ov));
                chk("done_cycle", cyc, e.due);
                repeat (2) @(posedge clk);
                for (int k = 0; k < NDIG; k++) seen[k] = 7'h55;
                for (int k = 0; k < NDIG * REFRESH; k++) begin
                    @(posedge clk);
                    #1;
                    d = digit_of(an);
                    if (d >= 0) seen[d] = a_to_g;
                end
                for (int k = 0; k < NDIG; k++)
                    chk($sformatf("seg_digit%0d", k), longint'(seen[k]), longint'(exp_seg(e.r, e.d0, k)));
                mon_cap = 1'b0;
            end
        end
    end

    // Scan checker: exactly one digit low, cyclic order, REFRESH cycles per digit
    always begin : scan_chk
        static logic [NDIG-1:0] prev_an = '1;
        static int last_dig = -1;
        static int last_chg = 0;
        static bit iv_ok    = 1'b0;
        int d;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            last_dig = -1;
            iv_ok    = 1'b0;
        end else if (an != prev_an) begin
            d = digit_of(an);
            chk("an_one_low", longint'(d >= 0), 1);
            if (last_dig >= 0) begin
                chk("scan_order", d, (last_dig + 1) % NDIG);
                if (iv_ok) chk("scan_interval", cyc - last_chg, REFRESH);
                iv_ok = 1'b1;
            end
            last_dig = d;
            last_chg = cyc;
        end
        prev_an = an;
    end

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || mon_cap) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("idle_wait_bound", longint'(t < 300), 1);
    endtask

    task automatic issue(input int av, input int bv, input int opv);
        exp_t e;
        bit   d0;
        @(posedge clk);
        #1;
        a     = av[W-1:0];
        b     = bv[W-1:0];
        op    = opv[2:0];
        start = 1'b1;
        e.r   = model(opv, av, bv, d0);
        e.d0  = d0;
        e.ov  = over(e.r);
        e.due = cyc + ((opv >= 2 && opv <= 4) ? W + 1 : 2);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_op(input int av, input int bv, input int opv);
        issue(av, bv, opv);
        wait_idle();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_done"}, longint'(done), 0);
        chk({tag, "_div0"}, longint'(div0), 0);
        chk({tag, "_ovf"}, longint'(ovf), 0);
        chk({tag, "_an"}, longint'(an), longint'({NDIG{1'b1}}));
        chk({tag, "_seg"}, longint'(a_to_g), 127);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

    initial begin : stim
        int av, bv, opv;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        chk("dp", longint'(dp), 1);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        do_op(-5, 3, 2);
        do_op(-7, 2, 3);
        do_op(-7, 2, 4);
        do_op(4, 0, 3);
        do_op(1, 1, 0);

        // second start during CALC must be ignored
        issue(6, -7, 2);
        repeat (1) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        do_op(-128, -128, 2);

        // reset in the middle of a multiply: no done, outputs back to reset values
        @(posedge clk);
        #1;
        a = 8'sd3; b = 8'sd5; op = 3'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midcalc_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_op(3, 4, 0);

        do_op(127, -128, 1);
        do_op(-128, -1, 3);
        do_op(-128, 0, 6);
        do_op(-128, 0, 5);
        do_op(100, 7, 7);

        for (int n = 0; n < 24; n++) begin
            av  = int'($urandom_range(0, 255)) - 128;
            bv  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 255)) - 128;
            opv = int'($urandom_range(0, 7));
            do_op(av, bv, opv);
        end

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
